// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types for the uart tx scheduler: FSM state encoding
// and the index-width helper used to size requester indices.
package uart_tx_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_START,
      ST_DRAIN
   } state_t;

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first valid requester at or after rr_ptr.
// Ports: req_valid, rr_ptr in; onehot, index, any out.
module uart_rr_pick
   import uart_tx_scheduler_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int IW = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IW-1:0]      rr_ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IW-1:0]      index,
   output logic               any
);

   localparam logic [IW:0] N_W = (IW+1)'(NUM_REQ);

   logic [IW:0] p;

   always_comb begin
      onehot = '0;
      index  = '0;
      any    = 1'b0;
      p      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         p = {1'b0, rr_ptr} + (IW+1)'(k);
         if (p >= N_W) p = p - N_W;
         if (!any && req_valid[p[IW-1:0]]) begin
            any               = 1'b1;
            index             = p[IW-1:0];
            onehot[p[IW-1:0]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart transmitter between NUM_REQ packet-locked requesters.
// Ports: req_* requester side, uart_* transmitter side, grant/active/timeout_err status.
module uart_tx_scheduler
   import uart_tx_scheduler_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ-1:0]   req_last,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 uart_start,
   output logic [7:0]           uart_data,
   input  logic                 uart_busy,
   output logic                 active,
   output logic                 timeout_err,
   input  logic                 err_clear
);

   localparam int IW = idx_w(NUM_REQ);
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_REQ - 1);

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [IW-1:0]        gidx_q, gidx_d;
   logic [IW-1:0]        rr_q, rr_d;
   logic                 start_q, start_d;
   logic [7:0]           data_q, data_d;
   logic                 last_q, last_d;
   logic [TW-1:0]        tmo_q, tmo_d;
   logic                 err_q, err_d;
   logic                 set_err;

   logic [NUM_REQ-1:0]   pick_oh;
   logic [IW-1:0]        pick_idx;
   logic                 pick_any;

   logic                 g_valid;
   logic [7:0]           g_byte;
   logic                 g_last;
   logic [IW-1:0]        rr_next;

   uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_valid (req_valid),
      .rr_ptr    (rr_q),
      .onehot    (pick_oh),
      .index     (pick_idx),
      .any       (pick_any)
   );

   assign g_valid = |(grant_q & req_valid);
   assign g_byte  = req_data[{gidx_q, 3'b000} +: 8];
   assign g_last  = req_last[gidx_q];
   // Next search starts just past the owner, so it cannot win twice
   // in a row while anyone else is waiting.
   assign rr_next = (gidx_q == IDX_MAX) ? '0 : gidx_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      gidx_d    = gidx_q;
      rr_d      = rr_q;
      start_d   = start_q;
      data_d    = data_q;
      last_d    = last_q;
      tmo_d     = tmo_q;
      set_err   = 1'b0;
      req_ready = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               grant_d = pick_oh;
               gidx_d  = pick_idx;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            req_ready = grant_q & req_valid;
            if (g_valid) begin
               data_d  = g_byte;
               last_d  = g_last;
               start_d = 1'b1;
               tmo_d   = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (uart_busy) begin
               start_d = 1'b0;
               state_d = ST_DRAIN;
            end else if (tmo_q == TMO_LAST) begin
               // Stuck transmitter: drop the rest of the packet.
               set_err = 1'b1;
               start_d = 1'b0;
               grant_d = '0;
               rr_d    = rr_next;
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (!uart_busy) begin
               if (last_q) begin
                  grant_d = '0;
                  rr_d    = rr_next;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_FETCH;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A new timeout outranks a simultaneous clear.
      err_d = set_err ? 1'b1 : (err_clear ? 1'b0 : err_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         rr_q    <= '0;
         start_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         rr_q    <= rr_d;
         start_q <= start_d;
         data_q  <= data_d;
         last_q  <= last_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   assign grant       = grant_q;
   assign uart_start  = start_q;
   assign uart_data   = data_q;
   assign active      = (state_q != ST_IDLE);
   assign timeout_err = err_q;

endmodule
